// File: rtl/li_ram_rd_arb.sv
// li_ram_rd_arb: two-requester round-robin arbiter in front of a single RAM
// read port. Issued reads are tagged with the requester id in an in-order
// tag FIFO so that RAM responses are routed back to the requester that
// issued them.
module li_ram_rd_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] r0_req_addr_in,
  input  logic                  r0_req_valid_in,
  output logic                  r0_req_ready_out,
  output logic [DATA_WIDTH-1:0] r0_resp_data_out,
  output logic                  r0_resp_valid_out,
  input  logic                  r0_resp_ready_in,

  input  logic [ADDR_WIDTH-1:0] r1_req_addr_in,
  input  logic                  r1_req_valid_in,
  output logic                  r1_req_ready_out,
  output logic [DATA_WIDTH-1:0] r1_resp_data_out,
  output logic                  r1_resp_valid_out,
  input  logic                  r1_resp_ready_in,

  output logic [ADDR_WIDTH-1:0] ram_rd_req_addr_out,
  output logic                  ram_rd_req_valid_out,
  input  logic                  ram_rd_req_ready_in,

  input  logic [DATA_WIDTH-1:0] ram_rd_resp_data_in,
  input  logic                  ram_rd_resp_valid_in,
  output logic                  ram_rd_resp_ready_out,

  output logic                  orphan_err_out
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // IDLE: no offer pending; HOLD: an offer is on the RAM channel and frozen.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Arbitration state: last granted id and the frozen offer while in HOLD.
  logic                  last_id;
  logic                  hold_id;
  logic [ADDR_WIDTH-1:0] hold_addr;

  // Tag FIFO: one bit per outstanding read holding the issuing requester id.
  logic [TAG_DEPTH-1:0]  tag_mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  head_id;

  logic                  arb_id;
  logic                  grant_id;
  logic                  push;
  logic                  pop;

  // Occupancy is registered, so a pop this cycle cannot make room for a push
  // in the same cycle.
  assign fifo_full  = (count == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (count == '0);
  assign head_id    = tag_mem[rd_ptr];

  // Fresh arbitration decision used only in IDLE: a lone valid requester wins,
  // otherwise the one not granted last.
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    arb_id = ~last_id;
    if (r0_req_valid_in && !r1_req_valid_in) begin
      arb_id = 1'b0;
    end else if (r1_req_valid_in && !r0_req_valid_in) begin
      arb_id = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this clock edge.
      state <= state_next;
    end
  end

  // Next-state logic: park in HOLD while an offer waits for the RAM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (ram_rd_req_valid_out && !ram_rd_req_ready_in) state_next = HOLD;
      HOLD: if (ram_rd_req_ready_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request-side outputs: live grant in IDLE, frozen offer in HOLD. The RAM
  // valid never looks at the RAM ready, and everything is forced low in reset.
  always_comb begin
    grant_id             = arb_id;
    ram_rd_req_addr_out  = arb_id ? r1_req_addr_in : r0_req_addr_in;
    ram_rd_req_valid_out = (arb_id ? r1_req_valid_in : r0_req_valid_in) && !fifo_full;
    if (state == HOLD) begin
      grant_id             = hold_id;
      ram_rd_req_addr_out  = hold_addr;
      ram_rd_req_valid_out = 1'b1;
    end
    ram_rd_req_valid_out = ram_rd_req_valid_out && !rst;
    r0_req_ready_out     = ram_rd_req_valid_out && ram_rd_req_ready_in && !grant_id;
    r1_req_ready_out     = ram_rd_req_valid_out && ram_rd_req_ready_in &&  grant_id;
  end

  assign push = ram_rd_req_valid_out && ram_rd_req_ready_in;

  // Response routing: the FIFO head picks the destination; both requesters
  // see the data, only the head requester sees valid.
  always_comb begin
    r0_resp_data_out      = ram_rd_resp_data_in;
    r1_resp_data_out      = ram_rd_resp_data_in;
    r0_resp_valid_out     = ram_rd_resp_valid_in && !fifo_empty && !head_id;
    r1_resp_valid_out     = ram_rd_resp_valid_in && !fifo_empty &&  head_id;
    ram_rd_resp_ready_out = !fifo_empty && (head_id ? r1_resp_ready_in : r0_resp_ready_in);
  end

  assign pop = ram_rd_resp_valid_in && ram_rd_resp_ready_out;

  // Round-robin pointer and frozen offer capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id   <= 1'b1;
      hold_id   <= 1'b0;
      hold_addr <= '0;
    end else begin
      if (push) begin
        last_id <= grant_id;
      end
      if (state == IDLE && ram_rd_req_valid_out && !ram_rd_req_ready_in) begin
        hold_id   <= grant_id;
        hold_addr <= ram_rd_req_addr_out;
      end
    end
  end

  // Tag storage write.
  always_ff @(posedge clk) begin
    // NOTE: the tag storage is not reset; entries are only read between the
    // reset-cleared pointers, so stale contents are never observed.
    if (push) begin
      tag_mem[wr_ptr] <= grant_id;
    end
  end

  // Tag FIFO pointers and occupancy; pointers wrap naturally at TAG_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error: a RAM response arrived with nothing outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orphan_err_out <= 1'b0;
    end else if (ram_rd_resp_valid_in && fifo_empty) begin
      orphan_err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_li_ram_rd_arb.sv
// Directed self-checking bench for li_ram_rd_arb. Inputs change 1 ns after
// the rising edge; outputs are compared 2 ns later, well before the next edge.
module tb_li_ram_rd_arb;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] r0_req_addr, r1_req_addr;
  logic          r0_req_valid, r1_req_valid;
  logic          r0_req_ready, r1_req_ready;
  logic [DW-1:0] r0_resp_data, r1_resp_data;
  logic          r0_resp_valid, r1_resp_valid;
  logic          r0_resp_ready, r1_resp_ready;
  logic [AW-1:0] ram_req_addr;
  logic          ram_req_valid, ram_req_ready;
  logic [DW-1:0] ram_resp_data;
  logic          ram_resp_valid, ram_resp_ready;
  logic          orphan_err;

  int checks = 0;
  int errors = 0;

  logic          iss_id   [0:7];
  logic [AW-1:0] iss_addr [0:7];
  logic          exp_id;
  logic [AW-1:0] exp_addr;

  always #5 clk = ~clk;

  li_ram_rd_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(4)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .r0_req_addr_in        (r0_req_addr),
    .r0_req_valid_in       (r0_req_valid),
    .r0_req_ready_out      (r0_req_ready),
    .r0_resp_data_out      (r0_resp_data),
    .r0_resp_valid_out     (r0_resp_valid),
    .r0_resp_ready_in      (r0_resp_ready),
    .r1_req_addr_in        (r1_req_addr),
    .r1_req_valid_in       (r1_req_valid),
    .r1_req_ready_out      (r1_req_ready),
    .r1_resp_data_out      (r1_resp_data),
    .r1_resp_valid_out     (r1_resp_valid),
    .r1_resp_ready_in      (r1_resp_ready),
    .ram_rd_req_addr_out   (ram_req_addr),
    .ram_rd_req_valid_out  (ram_req_valid),
    .ram_rd_req_ready_in   (ram_req_ready),
    .ram_rd_resp_data_in   (ram_resp_data),
    .ram_rd_resp_valid_in  (ram_resp_valid),
    .ram_rd_resp_ready_out (ram_resp_ready),
    .orphan_err_out        (orphan_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a requester already valid: nothing may be offered.
    rst = 1'b1;
    r0_req_addr = 8'h33; r0_req_valid = 1'b1;
    r1_req_addr = 8'h00; r1_req_valid = 1'b0;
    r0_resp_ready = 1'b0; r1_resp_ready = 1'b0;
    ram_req_ready = 1'b1;
    ram_resp_data = '0; ram_resp_valid = 1'b0;
    settle();
    check("rst_req_valid", 32'(ram_req_valid), 32'h0);
    check("rst_req_ready", 32'({r1_req_ready, r0_req_ready}), 32'h0);
    check("rst_resp_ready", 32'(ram_resp_ready), 32'h0);
    check("rst_resp_valid", 32'({r1_resp_valid, r0_resp_valid}), 32'h0);
    check("rst_orphan", 32'(orphan_err), 32'h0);
    step();
    step();
    rst = 1'b0;
    r0_req_valid = 1'b0;

    // Frozen offer: r0 @0x10 held while RAM stalls 3 cycles and r1 arrives.
    r0_req_valid = 1'b1; r0_req_addr = 8'h10; ram_req_ready = 1'b0;
    settle();
    check("hold_c1_valid", 32'(ram_req_valid), 32'h1);
    check("hold_c1_addr", 32'(ram_req_addr), 32'h10);
    check("hold_c1_ready", 32'({r1_req_ready, r0_req_ready}), 32'h0);
    step();
    r1_req_valid = 1'b1; r1_req_addr = 8'h20;
    settle();
    check("hold_c2_addr", 32'(ram_req_addr), 32'h10);
    check("hold_c2_valid", 32'(ram_req_valid), 32'h1);
    step();
    settle();
    check("hold_c3_addr", 32'(ram_req_addr), 32'h10);
    check("hold_c3_ready", 32'({r1_req_ready, r0_req_ready}), 32'h0);
    step();
    ram_req_ready = 1'b1;
    settle();
    check("hold_c4_addr", 32'(ram_req_addr), 32'h10);
    check("hold_c4_ready", 32'({r1_req_ready, r0_req_ready}), 32'h1);
    step();
    r0_req_valid = 1'b0;
    settle();
    check("r1_issue_addr", 32'(ram_req_addr), 32'h20);
    check("r1_issue_ready", 32'({r1_req_ready, r0_req_ready}), 32'h2);
    step();
    r1_req_valid = 1'b0;

    // Outstanding tags: [r0, r1]. First response goes to r0.
    ram_resp_valid = 1'b1; ram_resp_data = 16'hAAAA;
    r0_resp_ready = 1'b1; r1_resp_ready = 1'b0;
    settle();
    check("resp0_valid", 32'({r1_resp_valid, r0_resp_valid}), 32'h1);
    check("resp0_data", 32'(r0_resp_data), 32'hAAAA);
    check("resp0_ready", 32'(ram_resp_ready), 32'h1);
    step();
    // Head is r1 and r1 stalls for 5 cycles.
    ram_resp_data = 16'hBBBB;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("stall_valid", 32'({r1_resp_valid, r0_resp_valid}), 32'h2);
      check("stall_ready", 32'(ram_resp_ready), 32'h0);
      check("stall_data", 32'(r1_resp_data), 32'hBBBB);
      step();
    end
    r1_resp_ready = 1'b1;
    settle();
    check("release_ready", 32'(ram_resp_ready), 32'h1);
    check("release_valid", 32'({r1_resp_valid, r0_resp_valid}), 32'h2);
    check("release_data_r0", 32'(r0_resp_data), 32'hBBBB);
    step();

    // Orphan response with nothing outstanding.
    ram_resp_data = 16'hCCCC;
    settle();
    check("orphan_fwd", 32'({r1_resp_valid, r0_resp_valid}), 32'h0);
    check("orphan_ready", 32'(ram_resp_ready), 32'h0);
    check("orphan_same_cycle", 32'(orphan_err), 32'h0);
    step();
    ram_resp_valid = 1'b0;
    settle();
    check("orphan_set", 32'(orphan_err), 32'h1);
    step();
    step();
    settle();
    check("orphan_sticky", 32'(orphan_err), 32'h1);
    step();

    // Round robin: both requesters always valid, RAM always ready, responses
    // two cycles after issue. Last grant was r1, so r0 goes first.
    r0_resp_ready = 1'b1; r1_resp_ready = 1'b1; ram_req_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        r0_req_valid = 1'b1; r0_req_addr = 8'(8'h40 + c);
        r1_req_valid = 1'b1; r1_req_addr = 8'(8'h80 + c);
      end else begin
        r0_req_valid = 1'b0; r1_req_valid = 1'b0;
      end
      if (c >= 2) begin
        ram_resp_valid = 1'b1;
        ram_resp_data  = {8'h5A, iss_addr[c-2]};
      end else begin
        ram_resp_valid = 1'b0;
      end
      settle();
      if (c < 8) begin
        exp_id   = (c % 2) != 0;
        exp_addr = exp_id ? r1_req_addr : r0_req_addr;
        check("rr_addr", 32'(ram_req_addr), 32'(exp_addr));
        check("rr_ready", 32'({r1_req_ready, r0_req_ready}), exp_id ? 32'h2 : 32'h1);
        iss_id[c]   = exp_id;
        iss_addr[c] = exp_addr;
      end
      if (c >= 2) begin
        check("rr_resp_valid", 32'({r1_resp_valid, r0_resp_valid}), iss_id[c-2] ? 32'h2 : 32'h1);
        check("rr_resp_data", 32'(iss_id[c-2] ? r1_resp_data : r0_resp_data), 32'({8'h5A, iss_addr[c-2]}));
      end
      step();
    end
    ram_resp_valid = 1'b0;

    // Fill all four tag slots from r0 with no responses.
    r0_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r0_req_addr = 8'(i + 1);
      settle();
      check("fill_ready", 32'({r1_req_ready, r0_req_ready}), 32'h1);
      step();
    end
    r0_req_addr = 8'h05;
    settle();
    check("full_valid", 32'(ram_req_valid), 32'h0);
    check("full_ready", 32'({r1_req_ready, r0_req_ready}), 32'h0);
    step();
    // Pop one: the slot only frees up on the following cycle.
    ram_resp_valid = 1'b1; ram_resp_data = 16'h1111;
    settle();
    check("full_pop_ready", 32'(ram_resp_ready), 32'h1);
    check("full_pop_same_cycle", 32'(ram_req_valid), 32'h0);
    step();
    ram_resp_valid = 1'b0;
    settle();
    check("full_next_valid", 32'(ram_req_valid), 32'h1);
    check("full_next_ready", 32'({r1_req_ready, r0_req_ready}), 32'h1);
    check("full_next_addr", 32'(ram_req_addr), 32'h05);
    step();
    r0_req_valid = 1'b0;
    // Pop one more: three reads outstanding.
    ram_resp_valid = 1'b1; ram_resp_data = 16'h2222;
    settle();
    step();

    // Reset mid-traffic with three outstanding reads.
    r1_req_valid = 1'b1; r1_req_addr = 8'h77;
    settle();
    check("pre_rst_resp_ready", 32'(ram_resp_ready), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_req_valid", 32'(ram_req_valid), 32'h0);
    check("mid_rst_req_ready", 32'({r1_req_ready, r0_req_ready}), 32'h0);
    check("mid_rst_resp_valid", 32'({r1_resp_valid, r0_resp_valid}), 32'h0);
    check("mid_rst_resp_ready", 32'(ram_resp_ready), 32'h0);
    check("mid_rst_orphan", 32'(orphan_err), 32'h0);
    step();
    rst = 1'b0;
    r0_req_valid = 1'b1; r0_req_addr = 8'h21;
    r1_req_valid = 1'b1; r1_req_addr = 8'h22;
    ram_req_ready = 1'b0;
    settle();
    check("post_rst_grant_addr", 32'(ram_req_addr), 32'h21);
    check("post_rst_valid", 32'(ram_req_valid), 32'h1);
    check("post_rst_fifo_empty", 32'(ram_resp_ready), 32'h0);
    check("post_rst_no_fwd", 32'({r1_resp_valid, r0_resp_valid}), 32'h0);
    step();
    ram_resp_valid = 1'b0;
    ram_req_ready = 1'b1;
    settle();
    check("post_rst_grant_r0", 32'({r1_req_ready, r0_req_ready}), 32'h1);
    step();
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
